// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one word request at a time and queues {word, pc} for decode.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, WAIT_DROP} state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      word_mem_q [FIFO_DEPTH];
  logic [31:0]      word_mem_d [FIFO_DEPTH];
  logic [31:0]      pc_mem_q   [FIFO_DEPTH];
  logic [31:0]      pc_mem_d   [FIFO_DEPTH];

  logic fifo_empty;
  logic req_fire;
  logic resp_keep;
  logic bypass;
  logic push;
  logic pop;
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    fifo_empty     = (count_q == '0);
    imem_req_valid = rst_n && (state_q == IDLE) && (count_q < CNT_W'(FIFO_DEPTH)) && !redirect;
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    resp_keep      = (state_q == WAIT) && imem_resp_valid && !redirect;
`ifdef FETCH_BYPASS_EN
    bypass         = resp_keep && fifo_empty;
`else
    bypass         = 1'b0;
`endif
    inst_valid     = (!fifo_empty || bypass) && !redirect;
    instruction    = '0;
    inst_pc        = '0;
    if (!fifo_empty) begin
      instruction = word_mem_q[rd_ptr_q];
      inst_pc     = pc_mem_q[rd_ptr_q];
    end else if (bypass) begin
      instruction = imem_resp_data;
      inst_pc     = req_pc_q;
    end
    pop  = inst_valid && inst_ready && !fifo_empty;
    // A bypassed word that decode takes immediately never enters the queue.
    push = resp_keep && !(bypass && inst_ready);
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    word_mem_d = word_mem_q;
    pc_mem_d   = pc_mem_q;

    case (state_q)
      IDLE:      if (req_fire) state_d = WAIT;
      WAIT: begin
        if (imem_resp_valid)  state_d = IDLE;
        else if (redirect)    state_d = WAIT_DROP;
      end
      WAIT_DROP: if (imem_resp_valid) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      req_pc_d   = fetch_pc_q;
    end

    // Redirect wins over any same-cycle push, pop or request.
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        word_mem_d[wr_ptr_q] = imem_resp_data;
        pc_mem_d[wr_ptr_q]   = req_pc_q;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        word_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      word_mem_q <= word_mem_d;
      pc_mem_q   <= pc_mem_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: memory responder plus a queue-based reference of the fetch stage.
module tb_instruction_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] instruction, inst_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction), .inst_pc(inst_pc),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  typedef struct packed { logic [31:0] word; logic [31:0] pc; } ent_t;

  // Reference model: decode queue, fetch pointer, one outstanding request that is kept or dropped.
  ent_t        m_q[$];
  logic [31:0] m_fetch_pc, m_req_pc;
  bit          m_busy, m_keep;
  bit          e_byp;
  logic        e_rv, e_iv;
  logic [31:0] e_ra, e_in, e_ip;
  logic [96:0] exp_bus, obs_bus;
  localparam logic [96:0] RESET_BUS = {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0};

  // Memory responder: one pending word, returned mem_lat cycles after acceptance as addr + 0x13.
  bit          mem_pending, mem_rand_lat;
  logic [31:0] mem_addr;
  int          mem_due, mem_lat;

  int          cyc;
  bit          just_fired;
  logic [31:0] acc_log[$];
  ent_t        pop_log[$];
  int          n_checks, n_pass;

  assign obs_bus = {imem_req_valid, imem_req_addr, inst_valid, instruction, inst_pc};

  task automatic model_reset();
    m_q.delete();
    m_fetch_pc = RESET_PC;
    m_req_pc   = '0;
    m_busy     = 0;
    m_keep     = 0;
  endtask

  task automatic settle();
    if (mem_pending && cyc >= mem_due) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_addr + 32'h13;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    if (!rst_n) model_reset();
    e_byp = BYP && rst_n && m_busy && m_keep && (m_q.size() == 0) && imem_resp_valid && !redirect;
    e_rv  = rst_n && !m_busy && (m_q.size() < DEPTH) && !redirect;
    e_ra  = m_fetch_pc;
    e_iv  = rst_n && ((m_q.size() > 0) || e_byp) && !redirect;
    if (m_q.size() > 0) begin
      e_in = m_q[0].word; e_ip = m_q[0].pc;
    end else if (e_byp) begin
      e_in = imem_resp_data; e_ip = m_req_pc;
    end else begin
      e_in = '0; e_ip = '0;
    end
    exp_bus = {e_rv, e_ra, e_iv, e_in, e_ip};
    #1;
  endtask

  task automatic advance();
    bit dut_fire, resp;
    dut_fire   = imem_req_valid && imem_req_ready;
    resp       = imem_resp_valid;
    just_fired = dut_fire;
    if (dut_fire) acc_log.push_back(imem_req_addr);
    if (inst_valid && inst_ready) pop_log.push_back(ent_t'{instruction, inst_pc});
    if (resp) mem_pending = 0;
    if (dut_fire) begin
      mem_pending = 1;
      mem_addr    = imem_req_addr;
      mem_due     = cyc + (mem_rand_lat ? int'($urandom_range(1, 4)) : mem_lat);
    end
    if (rst_n) begin
      if (redirect) begin
        m_q.delete();
        m_fetch_pc = {redirect_pc[31:2], 2'b00};
        if (m_busy && resp) m_busy = 0;
        else if (m_busy)    m_keep = 0;
      end else begin
        if (e_byp) begin
          if (!inst_ready) m_q.push_back(ent_t'{imem_resp_data, m_req_pc});
        end else begin
          if (e_iv && inst_ready) void'(m_q.pop_front());
          if (m_busy && resp && m_keep) m_q.push_back(ent_t'{imem_resp_data, m_req_pc});
        end
        if (m_busy && resp) m_busy = 0;
        if (e_rv && imem_req_ready) begin
          m_busy     = 1;
          m_keep     = 1;
          m_req_pc   = m_fetch_pc;
          m_fetch_pc = m_fetch_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0; imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++;
      if (obs_bus !== RESET_BUS) $display("FAIL reset_outputs cyc=%0d got=%h exp=%h", cyc, obs_bus, RESET_BUS);
      else n_pass++;
      advance();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_fetch();
    int acc_cyc = -1, iv_cyc = -1;
    mem_rand_lat = 0; mem_lat = 1; inst_ready = 1'b1; imem_req_ready = 1'b1;
    acc_log.delete(); pop_log.delete();
    for (int i = 0; i < 10; i++) begin
      settle();
      if (imem_req_valid && imem_req_ready && acc_cyc < 0) acc_cyc = cyc;
      if (inst_valid && iv_cyc < 0) iv_cyc = cyc;
      n_checks++;
      if (obs_bus !== exp_bus) $display("FAIL basic_cycle cyc=%0d got=%h exp=%h", cyc, obs_bus, exp_bus);
      else n_pass++;
      advance();
    end
    n_checks++;
    if (acc_cyc < 0 || iv_cyc - acc_cyc != (BYP ? 1 : 2))
      $display("FAIL basic_latency got=%0d exp=%0d", iv_cyc - acc_cyc, BYP ? 1 : 2);
    else n_pass++;
    n_checks++;
    if (acc_log.size() < 3 || acc_log[0] !== 32'h0 || acc_log[1] !== 32'h4 || acc_log[2] !== 32'h8)
      $display("FAIL basic_req_addrs got=%h,%h,%h exp=0,4,8", acc_log[0], acc_log[1], acc_log[2]);
    else n_pass++;
    n_checks++;
    if (pop_log.size() < 2 || {pop_log[0].word, pop_log[0].pc} !== {32'h13, 32'h0} ||
        {pop_log[1].word, pop_log[1].pc} !== {32'h17, 32'h4})
      $display("FAIL basic_decode got=%h,%h exp=13@0,17@4", pop_log[0], pop_log[1]);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      settle();
      n_checks++;
      if (obs_bus !== exp_bus) $display("FAIL bp_stall_cycle cyc=%0d got=%h exp=%h", cyc, obs_bus, exp_bus);
      else n_pass++;
      if (i == 9) begin
        n_checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b1)
          $display("FAIL bp_full got req_valid=%b inst_valid=%b exp 0,1", imem_req_valid, inst_valid);
        else n_pass++;
      end
      advance();
    end
    acc_log.delete(); pop_log.delete();
    inst_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      settle();
      n_checks++;
      if (obs_bus !== exp_bus) $display("FAIL bp_drain_cycle cyc=%0d got=%h exp=%h", cyc, obs_bus, exp_bus);
      else n_pass++;
      advance();
    end
    n_checks++;
    if (pop_log.size() < 4 || acc_log.size() < 1 || acc_log[0] !== pop_log[0].pc + 32'd8)
      $display("FAIL bp_next_req got=%h exp=%h pops=%0d", acc_log[0], pop_log[0].pc + 32'd8, pop_log.size());
    else n_pass++;
    for (int i = 1; i < pop_log.size(); i++) begin
      n_checks++;
      if (pop_log[i].pc !== pop_log[0].pc + 32'(4 * i) || pop_log[i].word !== pop_log[i].pc + 32'h13)
        $display("FAIL bp_sequence idx=%0d got=%h exp_pc=%h", i, pop_log[i], pop_log[0].pc + 32'(4 * i));
      else n_pass++;
    end
  endtask

  task automatic test_redirect_wait();
    bit found = 0;
    mem_lat = 3; inst_ready = 1'b1; imem_req_ready = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      settle();
      n_checks++;
      if (obs_bus !== exp_bus) $display("FAIL rw_pre_cycle cyc=%0d got=%h exp=%h", cyc, obs_bus, exp_bus);
      else n_pass++;
      advance();
      found = just_fired;
    end
    n_checks++;
    if (!found) $display("FAIL rw_no_request got=none exp=accepted request");
    else n_pass++;
    acc_log.delete(); pop_log.delete();
    redirect = 1'b1; redirect_pc = 32'h100;
    for (int i = 0; i < 15; i++) begin
      settle();
      n_checks++;
      if (obs_bus !== exp_bus) $display("FAIL rw_cycle cyc=%0d got=%h exp=%h", cyc, obs_bus, exp_bus);
      else n_pass++;
      advance();
      redirect = 1'b0;
    end
    n_checks++;
    if (acc_log.size() < 1 || acc_log[0] !== 32'h100 || pop_log.size() < 1 ||
        {pop_log[0].word, pop_log[0].pc} !== {32'h113, 32'h100})
      $display("FAIL rw_refetch got req=%h pop=%h exp req=100 pop=113@100", acc_log[0], pop_log[0]);
    else n_pass++;
  endtask

  task automatic test_redirect_with_resp();
    bit found = 0;
    mem_lat = 2; inst_ready = 1'b1; imem_req_ready = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_pending && cyc >= mem_due) found = 1;
      else begin
        settle();
        n_checks++;
        if (obs_bus !== exp_bus) $display("FAIL rr_pre_cycle cyc=%0d got=%h exp=%h", cyc, obs_bus, exp_bus);
        else n_pass++;
        advance();
      end
    end
    n_checks++;
    if (!found) $display("FAIL rr_no_response got=none exp=response");
    else n_pass++;
    acc_log.delete(); pop_log.delete();
    redirect = 1'b1; redirect_pc = 32'h203;
    settle();
    n_checks++;
    if (obs_bus !== exp_bus) $display("FAIL rr_redirect_cycle got=%h exp=%h", obs_bus, exp_bus);
    else n_pass++;
    advance();
    redirect = 1'b0;
    settle();
    n_checks++;
    if ({inst_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h200})
      $display("FAIL rr_after got iv=%b rv=%b addr=%h exp iv=0 rv=1 addr=200", inst_valid, imem_req_valid, imem_req_addr);
    else n_pass++;
    advance();
    for (int i = 0; i < 8; i++) begin
      settle();
      n_checks++;
      if (obs_bus !== exp_bus) $display("FAIL rr_cycle cyc=%0d got=%h exp=%h", cyc, obs_bus, exp_bus);
      else n_pass++;
      advance();
    end
    n_checks++;
    if (pop_log.size() < 1 || {pop_log[0].word, pop_log[0].pc} !== {32'h213, 32'h200})
      $display("FAIL rr_first_decode got=%h exp=213@200", pop_log[0]);
    else n_pass++;
  endtask

  task automatic test_req_stall();
    redirect = 1'b1; redirect_pc = 32'h8; inst_ready = 1'b1; imem_req_ready = 1'b0;
    settle();
    advance();
    redirect = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      n_checks++;
      if (obs_bus !== exp_bus || imem_req_addr !== 32'h8)
        $display("FAIL stall_hold cyc=%0d got=%h exp=%h", cyc, obs_bus, exp_bus);
      else n_pass++;
      advance();
    end
    acc_log.delete();
    imem_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      n_checks++;
      if (obs_bus !== exp_bus) $display("FAIL stall_release cyc=%0d got=%h exp=%h", cyc, obs_bus, exp_bus);
      else n_pass++;
      advance();
    end
    n_checks++;
    if (acc_log.size() < 2 || acc_log[0] !== 32'h8 || acc_log[1] !== 32'hC)
      $display("FAIL stall_addrs got=%h,%h exp=8,c", acc_log[0], acc_log[1]);
    else n_pass++;
  endtask

  task automatic test_pc_wrap();
    mem_lat = 1; inst_ready = 1'b1; imem_req_ready = 1'b1;
    acc_log.delete(); pop_log.delete();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFA;
    for (int i = 0; i < 12; i++) begin
      settle();
      n_checks++;
      if (obs_bus !== exp_bus) $display("FAIL wrap_cycle cyc=%0d got=%h exp=%h", cyc, obs_bus, exp_bus);
      else n_pass++;
      advance();
      redirect = 1'b0;
    end
    n_checks++;
    if (acc_log.size() < 3 || acc_log[0] !== 32'hFFFF_FFF8 || acc_log[1] !== 32'hFFFF_FFFC || acc_log[2] !== 32'h0)
      $display("FAIL wrap_addrs got=%h,%h,%h exp=fffffff8,fffffffc,0", acc_log[0], acc_log[1], acc_log[2]);
    else n_pass++;
    n_checks++;
    if (pop_log.size() < 2 || {pop_log[1].word, pop_log[1].pc} !== {32'h0000_000F, 32'hFFFF_FFFC})
      $display("FAIL wrap_decode got=%h exp=f@fffffffc", pop_log[1]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_request();
    bit found = 0;
    mem_lat = 6; inst_ready = 1'b1; imem_req_ready = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      settle();
      advance();
      found = just_fired;
    end
    n_checks++;
    if (!found) $display("FAIL rm_no_request got=none exp=accepted request");
    else n_pass++;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_checks++;
      if (obs_bus !== RESET_BUS) $display("FAIL rm_reset_outputs cyc=%0d got=%h exp=%h", cyc, obs_bus, RESET_BUS);
      else n_pass++;
      advance();
    end
    rst_n = 1'b1; imem_req_ready = 1'b0;
    acc_log.delete(); pop_log.delete();
    for (int i = 0; i < 8; i++) begin
      settle();
      n_checks++;
      if (obs_bus !== exp_bus || inst_valid !== 1'b0)
        $display("FAIL rm_stale_ignored cyc=%0d got=%h exp=%h", cyc, obs_bus, exp_bus);
      else n_pass++;
      advance();
    end
    imem_req_ready = 1'b1; mem_lat = 1;
    for (int i = 0; i < 6; i++) begin
      settle();
      n_checks++;
      if (obs_bus !== exp_bus) $display("FAIL rm_restart_cycle cyc=%0d got=%h exp=%h", cyc, obs_bus, exp_bus);
      else n_pass++;
      advance();
    end
    n_checks++;
    if (acc_log.size() < 1 || acc_log[0] !== RESET_PC || pop_log.size() < 1 ||
        {pop_log[0].word, pop_log[0].pc} !== {RESET_PC + 32'h13, RESET_PC})
      $display("FAIL rm_restart got req=%h pop=%h exp req=%h", acc_log[0], pop_log[0], RESET_PC);
    else n_pass++;
  endtask

  task automatic test_random();
    mem_rand_lat = 1;
    for (int i = 0; i < 600; i++) begin
      redirect       = ($urandom_range(0, 99) < 6);
      redirect_pc    = $urandom;
      inst_ready     = ($urandom_range(0, 99) < 65);
      imem_req_ready = ($urandom_range(0, 99) < 70);
      settle();
      n_checks++;
      if (obs_bus !== exp_bus) $display("FAIL random_cycle cyc=%0d got=%h exp=%h", cyc, obs_bus, exp_bus);
      else n_pass++;
      advance();
    end
    redirect = 1'b0;
    mem_rand_lat = 0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0;
    mem_pending = 0; mem_rand_lat = 0; mem_lat = 1; mem_due = 0; mem_addr = '0;
    imem_resp_valid = 1'b0; imem_resp_data = '0;
    model_reset();
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_redirect_wait();
    test_redirect_with_resp();
    test_req_stall();
    test_pc_wrap();
    test_reset_mid_request();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage directly upstream of instruction_decoder. It owns the program counter and issues word requests to instruction memory. It holds returned words in a small FIFO and presents {instruction, pc} to decode over a valid/ready handshake. A redirect from execute (taken branch, JAL, JALR) flushes the FIFO, discards any in-flight response and restarts fetch at the new PC.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset; low 2 bits must be 0
FIFO_DEPTH, 2, fetch queue entries; power of two, >= 2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  32  word-aligned fetch address
imem_resp_valid  in  1  response data valid (one per accepted request, in order, >= 1 cycle after acceptance)
imem_resp_data  in  32  instruction word
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts instruction
instruction  out  32  instruction word to decoder
inst_pc  out  32  PC of that instruction
redirect  in  1  flush and refetch
redirect_pc  in  32  new fetch PC

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low. All state is cleared on assertion: fetch_pc=RESET_PC, FIFO empty, state IDLE, drop flag 0.
- Outputs during reset: imem_req_valid=0, inst_valid=0, instruction=0, inst_pc=0, imem_req_addr=RESET_PC.
- At most one outstanding memory request.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; its response will be kept.
  - WAIT_DROP: request outstanding; its response will be discarded.
- Transitions:
  - IDLE -> WAIT on imem_req_valid && imem_req_ready.
  - WAIT -> IDLE on imem_resp_valid; data pushed into the FIFO.
  - WAIT -> WAIT_DROP on redirect without imem_resp_valid.
  - WAIT -> IDLE on redirect with imem_resp_valid; the response is discarded.
  - WAIT_DROP -> IDLE on imem_resp_valid; data discarded, no FIFO write.
- imem_req_valid = (state==IDLE) && (FIFO count < FIFO_DEPTH) && !redirect. It is combinational. Withdrawal on redirect is legal for the memory side.
- imem_req_addr = fetch_pc. fetch_pc increments by 4 on request handshake; 32-bit wrap 32'hFFFF_FFFC -> 0.
- Each FIFO entry stores {word, pc}, where pc is the fetch_pc of the issued request, captured into a request-pc register.
- Decode side:
  - inst_valid = FIFO not empty && !redirect.
  - instruction/inst_pc = head entry; 0 when empty.
  - Pop on inst_valid && inst_ready.
- Redirect (single-cycle pulse or held), evaluated at the clock edge:
  - FIFO cleared.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - A same-cycle pop or response push has no effect.
  - Redirect has priority over every other event.
- Simultaneous push and pop with FIFO full: the push cannot occur, because no request is issued when full.
- Simultaneous push and pop with FIFO non-full: both take effect and count is unchanged.
- Latency without bypass: request accepted at T, response at T+k, inst_valid at T+k+1.
- Throughput: one instruction every 2 cycles with 1-cycle memory.
- Reset asserted mid-request: state returns to IDLE immediately, and a later stale imem_resp_valid while still in IDLE is ignored.

Optional Feature:
FETCH_BYPASS_EN
- Defined:
  - When the FIFO is empty, state is WAIT and imem_resp_valid=1 (no redirect): inst_valid=1 in the same cycle, with instruction=imem_resp_data and inst_pc=request pc.
  - If inst_ready=1 in that cycle, the word is consumed and not written; otherwise it is pushed.
  - Latency becomes T+k.
- Undefined: all responses go through the FIFO, as described in Behaviour.

Test Plan:
1. Reset release, 1-cycle memory returning addr+32'h13 -> requests 0x0, 0x4, 0x8; decode sees (0x13 @0x0), (0x17 @0x4) in order; inst_valid first at cycle 3 (cycle 2 with FETCH_BYPASS_EN).
2. inst_ready=0 for 10 cycles -> FIFO fills to 2; imem_req_valid stays 0; after release, entries 0x0, 0x4 drain and then 0x8 is requested, with no loss or duplication.
3. Redirect to 0x100 while in WAIT, with the response arriving 2 cycles later -> stale word dropped; next request addr 0x100; first decoded inst_pc=0x100.
4. Redirect to 0x203 on the same cycle as imem_resp_valid and inst_ready -> FIFO empty next cycle; response discarded; next request addr 0x200.
5. imem_req_ready=0 for 5 cycles -> imem_req_addr held at 0x8, fetch_pc not advanced; proceeds on ready.
6. RESET_PC=32'hFFFF_FFFC -> first request 0xFFFF_FFFC, second 0x0; rst_n asserted during WAIT -> outputs at reset values, fetch restarts at RESET_PC.
